move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the cycles an encoded button code must stay unchanged before acceptance (legal range 2..65535).
REQ-002 Parameter START_X, default 3'd0, SHALL set the reset value of posx.
REQ-003 Parameter START_Y, default 2'd0, SHALL set the reset value of posy.
REQ-004 Ports SHALL be, clock and reset first:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_right, btn_left  input  1 each  raw asynchronous push buttons, active-high.
- next_posx  input  3  resolved x from the move-legality stage.
- next_posy  input  2  resolved y from the move-legality stage.
- dir  output  3  requested direction: UP=000, DOWN=001, RIGHT=010, LEFT=011, NONE=100.
- valid  output  1  move request strobe to the move-legality stage.
- posx  output  3  registered player x, fed to the move-legality stage.
- posy  output  2  registered player y, fed to the move-legality stage.
- moved  output  1  one-cycle pulse: committed position differs from previous.
- blocked  output  1  one-cycle pulse: request issued, position unchanged.
- move_count  output  8  count of moved pulses, saturating.

Function
REQ-005 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-006 Synchronized buttons SHALL encode to one code: exactly one asserted gives its direction; zero or two-plus asserted gives NONE.
REQ-007 A 16-bit debounce counter SHALL clear whenever the encoded code differs from its previous-cycle value, and SHALL otherwise increment, saturating at DEBOUNCE_CYCLES-1.
REQ-008 The stable code SHALL update to the encoded code in the cycle the counter reaches DEBOUNCE_CYCLES-1. It SHALL reset to NONE.
REQ-009 FSM states SHALL be IDLE, ISSUE, HOLD; reset state IDLE.
REQ-010 IDLE -> ISSUE when the stable code is not NONE; otherwise remain IDLE.
REQ-011 ISSUE SHALL last exactly one cycle. It drives valid=1 and dir=the stable code captured on entry. It then goes to HOLD.
REQ-012 In every state other than ISSUE, valid SHALL be 0 and dir SHALL be NONE.
REQ-013 On the clock edge ending ISSUE, posx/posy SHALL load next_posx/next_posy. The legality stage is combinational, so next_pos is valid in the same cycle.
REQ-014 posx/posy SHALL change only on that edge or on reset.
REQ-015 HOLD -> IDLE only when the stable code is NONE. One press yields exactly one move; holding a button never auto-repeats.
REQ-016 A different direction pressed while in HOLD without an intervening stable NONE SHALL NOT issue a move.
REQ-017 moved SHALL pulse one cycle after ISSUE when {next_posy,next_posx} != {posy,posx} sampled in ISSUE. Otherwise blocked SHALL pulse in that cycle.
REQ-018 moved and blocked SHALL never assert together, and SHALL never assert outside the cycle after ISSUE.
REQ-019 move_count SHALL increment on each moved pulse and hold at 8'd255.
REQ-020 The block SHALL NOT clamp coordinates. Wrap-around returned by the legality stage (e.g. x 7 -> 0) SHALL be committed as given.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- synchronizers 0, debounce counter 0, stable code NONE, FSM IDLE;
- posx=START_X, posy=START_Y;
- dir=NONE, valid=0, moved=0, blocked=0, move_count=0.
REQ-022 Reset asserted mid-ISSUE or mid-HOLD SHALL abort with no position commit. After release, the block SHALL require a fresh debounced press.
REQ-023 Reset deassertion is synchronized externally; no output SHALL glitch on release.

Verification
REQ-024 Benches SHALL use DEBOUNCE_CYCLES=4 and loop next_pos through a behavioural legality model that matches the team's obstacle map.
REQ-025 Scenario: reset at (0,0), press btn_right for 10 cycles, then release.
- Exactly one valid pulse with dir=010.
- posx=1, moved pulse, move_count=1.
REQ-026 Scenario: at (2,0), press btn_right; the target (3,0) is an obstacle.
- valid pulse issued, posx stays 2, blocked pulse, move_count unchanged.
REQ-027 Scenario: toggle btn_up at a 2-cycle period for 20 cycles.
- No valid pulse, position unchanged.
REQ-028 Scenario: hold btn_down 100 cycles at (1,0).
- Single move to (1,1).
- Pressing btn_left while still in HOLD issues nothing until the buttons are released and re-pressed.
REQ-029 Scenario: btn_up and btn_left pressed together.
- Code NONE, no request.
REQ-030 Scenario: assert rst_n low in the ISSUE cycle.
- posx/posy return to START values immediately, valid drops, move_count=0.

Source files
------------

// File: rtl/move_controller.sv
// Button-driven move requester: synchronizes and debounces four push buttons,
// issues one move request per press and commits the position the legality stage returns.
module move_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [2:0]  START_X         = 3'd0,
  parameter logic [1:0]  START_Y         = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic [2:0] next_posx,
  input  logic [1:0] next_posy,
  output logic [2:0] dir,
  output logic       valid,
  output logic [2:0] posx,
  output logic [1:0] posy,
  output logic       moved,
  output logic       blocked,
  output logic [7:0] move_count
);

  localparam logic [2:0]  DIR_UP    = 3'b000;
  localparam logic [2:0]  DIR_DOWN  = 3'b001;
  localparam logic [2:0]  DIR_RIGHT = 3'b010;
  localparam logic [2:0]  DIR_LEFT  = 3'b011;
  localparam logic [2:0]  DIR_NONE  = 3'b100;
  localparam logic [15:0] CNT_MAX   = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Valid/ready contract: valid is a single-cycle request with no ready; the legality
  // stage is combinational and answers via next_posx/next_posy in that same cycle.

  logic [3:0]  btn_raw;
  logic [3:0]  sync1_q, sync2_q;
  logic [2:0]  code_enc;
  logic [2:0]  code_prev_q, code_prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  stable_q, stable_d;
  state_e      state_q, state_d;
  logic [2:0]  dir_q, dir_d;
  logic [2:0]  posx_q, posx_d;
  logic [1:0]  posy_q, posy_d;
  logic        moved_q, moved_d;
  logic        blocked_q, blocked_d;
  logic [7:0]  count_q, count_d;

  assign btn_raw = {btn_left, btn_right, btn_down, btn_up};

  always_comb begin
    code_enc = DIR_NONE;
    case (sync2_q)
      4'b0001: code_enc = DIR_UP;
      4'b0010: code_enc = DIR_DOWN;
      4'b0100: code_enc = DIR_RIGHT;
      4'b1000: code_enc = DIR_LEFT;
      default: code_enc = DIR_NONE;
    endcase
  end

  // Stable code only takes a value that has held unchanged for the full debounce window.
  always_comb begin
    code_prev_d = code_enc;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    if (code_enc != code_prev_q) begin
      cnt_d = 16'd0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
      if (cnt_q == CNT_MAX) stable_d = code_enc;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    posx_d    = posx_q;
    posy_d    = posy_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (stable_q != DIR_NONE) begin
          state_d = ISSUE;
          dir_d   = stable_q;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        posx_d  = next_posx;
        posy_d  = next_posy;
        if ({next_posy, next_posx} != {posy_q, posx_q}) begin
          moved_d = 1'b1;
          if (count_q != 8'd255) count_d = count_q + 8'd1;
        end else begin
          blocked_d = 1'b1;
        end
      end
      HOLD: begin
        // A direction change without a stable release in between must not re-arm.
        if (stable_q == DIR_NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      code_prev_q <= DIR_NONE;
      cnt_q       <= 16'd0;
      stable_q    <= DIR_NONE;
      state_q     <= IDLE;
      dir_q       <= DIR_NONE;
      posx_q      <= START_X;
      posy_q      <= START_Y;
      moved_q     <= 1'b0;
      blocked_q   <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      code_prev_q <= code_prev_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      dir_q       <= dir_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
      moved_q     <= moved_d;
      blocked_q   <= blocked_d;
      count_q     <= count_d;
    end
  end

  assign valid      = (state_q == ISSUE);
  assign dir        = (state_q == ISSUE) ? dir_q : DIR_NONE;
  assign posx       = posx_q;
  assign posy       = posy_q;
  assign moved      = moved_q;
  assign blocked    = blocked_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: obstacle-map legality model in the loop, expected
// requests queued by the stimulus and popped by an independent monitor.
module tb_move_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;  // {left, right, down, up}
  logic [2:0] next_posx;
  logic [1:0] next_posy;
  logic [2:0] dir;
  logic       valid;
  logic [2:0] posx;
  logic [1:0] posy;
  logic       moved;
  logic       blocked;
  logic [7:0] move_count;

  int total = 0;
  int bad   = 0;

  // Entry: {dir[16:14], moved[13], posx[12:10], posy[9:8], count[7:0]}
  logic [16:0] exp_q[$];
  logic [16:0] cur;
  logic        pending = 1'b0;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_DOWN  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b1000;

  move_controller #(
    .DEBOUNCE_CYCLES(4),
    .START_X(3'd0),
    .START_Y(2'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn[0]),
    .btn_down(btn[1]),
    .btn_right(btn[2]),
    .btn_left(btn[3]),
    .next_posx(next_posx),
    .next_posy(next_posy),
    .dir(dir),
    .valid(valid),
    .posx(posx),
    .posy(posy),
    .moved(moved),
    .blocked(blocked),
    .move_count(move_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legality model: 8x4 torus with a single obstacle at (3,0); UP decrements y.
  always_comb begin
    logic [2:0] tx;
    logic [1:0] ty;
    tx = posx;
    ty = posy;
    case (dir)
      3'b000: ty = posy - 2'd1;
      3'b001: ty = posy + 2'd1;
      3'b010: tx = posx + 3'd1;
      3'b011: tx = posx - 3'd1;
      default: ;
    endcase
    if (tx == 3'd3 && ty == 2'd0) begin
      tx = posx;
      ty = posy;
    end
    next_posx = tx;
    next_posy = ty;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (moved && blocked) check("moved_and_blocked", 1, 0);
      if (pending) begin
        pending = 1'b0;
        check("moved",      int'(moved),      int'(cur[13]));
        check("blocked",    int'(blocked),    int'(!cur[13]));
        check("posx",       int'(posx),       int'(cur[12:10]));
        check("posy",       int'(posy),       int'(cur[9:8]));
        check("move_count", int'(move_count), int'(cur[7:0]));
      end else if (moved || blocked) begin
        check("stray_outcome", 1, 0);
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(dir), 4);
        end else begin
          cur = exp_q.pop_front();
          check("dir", int'(dir), int'(cur[16:14]));
          pending = 1'b1;
        end
      end
    end
  end

  // Driver tasks
  task automatic press(input logic [3:0] mask, input int hold, input int rel);
    @(negedge clk);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 4'd0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic press_move(input logic [2:0] d, input logic [3:0] mask, input logic mv,
                            input logic [2:0] ex, input logic [1:0] ey, input logic [7:0] ec);
    exp_q.push_back({d, mv, ex, ey, ec});
    press(mask, 10, 12);
  endtask

  initial begin
    int k;
    int ecnt;
    logic [2:0] ex;
    btn   = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_posx",  int'(posx), 0);
    check("rst_posy",  int'(posy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_dir",   int'(dir), 4);
    check("rst_moved", int'(moved), 0);
    check("rst_blocked", int'(blocked), 0);
    check("rst_count", int'(move_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic moves, then blocked by obstacle at (3,0)
    press_move(3'b010, B_RIGHT, 1'b1, 3'd1, 2'd0, 8'd1);
    press_move(3'b010, B_RIGHT, 1'b1, 3'd2, 2'd0, 8'd2);
    press_move(3'b010, B_RIGHT, 1'b0, 3'd2, 2'd0, 8'd2);

    // Bouncing up button never settles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn = (i % 2 == 0) ? B_UP : 4'd0;
    end
    btn = 4'd0;
    repeat (12) @(negedge clk);
    check("bounce_posx", int'(posx), 2);
    check("bounce_posy", int'(posy), 0);

    // Long hold gives one move; switching direction in HOLD does nothing
    press_move(3'b011, B_LEFT, 1'b1, 3'd1, 2'd0, 8'd3);
    exp_q.push_back({3'b001, 1'b1, 3'd1, 2'd1, 8'd4});
    @(negedge clk);
    btn = B_DOWN;
    repeat (100) @(negedge clk);
    btn = B_LEFT;
    repeat (30) @(negedge clk);
    btn = 4'd0;
    repeat (12) @(negedge clk);
    check("hold_posx", int'(posx), 1);
    check("hold_posy", int'(posy), 1);
    press_move(3'b011, B_LEFT, 1'b1, 3'd0, 2'd1, 8'd5);

    // Two buttons together encode to NONE
    press(B_UP | B_LEFT, 20, 12);

    // Wrap-around committed as given
    press_move(3'b011, B_LEFT, 1'b1, 3'd7, 2'd1, 8'd6);
    press_move(3'b000, B_UP,   1'b1, 3'd7, 2'd0, 8'd7);
    press_move(3'b000, B_UP,   1'b1, 3'd7, 2'd3, 8'd8);

    // Reset during ISSUE
    @(negedge clk);
    btn = B_RIGHT;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      if (valid) break;
      k++;
    end
    check("issue_seen", int'(k < 40), 1);
    rst_n = 1'b0;
    #1;
    check("abort_posx",  int'(posx), 0);
    check("abort_posy",  int'(posy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_count", int'(move_count), 0);
    btn = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_abort_posx", int'(posx), 0);
    press_move(3'b001, B_DOWN, 1'b1, 3'd0, 2'd1, 8'd1);

    // Saturation of move_count along obstacle-free row y=1
    ecnt = 1;
    ex   = 3'd0;
    for (int i = 0; i < 260; i++) begin
      ex = ex + 3'd1;
      if (ecnt < 255) ecnt++;
      press_move(3'b010, B_RIGHT, 1'b1, ex, 2'd1, 8'(ecnt));
    end

    repeat (5) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
